// File: rtl/pcru_pkg.sv
// Shared types for the PC redirect unit: EXE correction encodings and next-PC select codes.
package pcru_pkg;

  localparam logic [1:0] CORR_NONE = 2'b00;
  localparam logic [1:0] CORR_CNI  = 2'b10;
  localparam logic [1:0] CORR_PBT  = 2'b11;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_IFPBT,
    SEL_HOLD,
    SEL_CNI,
    SEL_EXEPBT
  } next_pc_sel_e;

endpackage

// File: rtl/pcru_shadow_stage.sv
// One {valid, pred} slot of the IF->ID->EXE shadow pipeline; flush clears it even under stall.
module pcru_shadow_stage (
  input  logic CLK,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  input  logic d_valid,
  input  logic d_pred,
  output logic q_valid,
  output logic q_pred
);

  logic valid_reg;
  logic pred_reg;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pred_reg  <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      pred_reg  <= 1'b0;
    end else if (!stall) begin
      valid_reg <= d_valid;
      pred_reg  <= d_pred;
    end
  end

  assign q_valid = valid_reg;
  assign q_pred  = pred_reg;

endmodule

// File: rtl/pc_redirect_unit.sv
// IF-stage next-PC generator with EXE mispredict redirect and flush.
// Optional saturating perf counters are built only when PCRU_PERF_CNT_EN is defined.
module pc_redirect_unit
  import pcru_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int PC_INC  = 1,
  parameter int BOOT_PC = 0,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_prediction,
  input  logic [PC_W-1:0]  if_PBT,
  input  logic [1:0]       exe_correction,
  input  logic [PC_W-1:0]  exe_PBT,
  input  logic [PC_W-1:0]  exe_CNI,
  output logic [PC_W-1:0]  if_pc,
  output logic [PC_W-1:0]  next_pc,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             id_pred_taken,
  output logic             exe_pred_taken,
  output logic             flush,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam logic [PC_W-1:0] BOOT_PC_C = PC_W'(BOOT_PC);
  localparam logic [PC_W-1:0] PC_INC_C  = PC_W'(PC_INC);

  logic            redirect;
  logic [PC_W-1:0] if_pc_reg;
  next_pc_sel_e    sel;

  // A correction only counts when a live instruction sits in EXE.
  assign redirect = exe_valid & exe_correction[1];
  assign flush    = redirect;

  always_comb begin
    sel = SEL_SEQ;
    if (redirect && (exe_correction == CORR_PBT))
      sel = SEL_EXEPBT;
    else if (redirect && (exe_correction == CORR_CNI))
      sel = SEL_CNI;
    else if (stall)
      sel = SEL_HOLD;
    else if (if_prediction)
      sel = SEL_IFPBT;
  end

  always_comb begin
    next_pc = if_pc_reg + PC_INC_C;
    case (sel)
      SEL_EXEPBT: next_pc = exe_PBT;
      SEL_CNI:    next_pc = exe_CNI;
      SEL_HOLD:   next_pc = if_pc_reg;
      SEL_IFPBT:  next_pc = if_PBT;
      default:    next_pc = if_pc_reg + PC_INC_C;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst)
      if_pc_reg <= BOOT_PC_C;
    else
      if_pc_reg <= next_pc;
  end

  assign if_pc = if_pc_reg;

  pcru_shadow_stage u_id_stage (
    .CLK     (CLK),
    .rst     (rst),
    .stall   (stall),
    .flush   (redirect),
    .d_valid (1'b1),
    .d_pred  (if_prediction),
    .q_valid (id_valid),
    .q_pred  (id_pred_taken)
  );

  pcru_shadow_stage u_exe_stage (
    .CLK     (CLK),
    .rst     (rst),
    .stall   (stall),
    .flush   (redirect),
    .d_valid (id_valid),
    .d_pred  (id_pred_taken),
    .q_valid (exe_valid),
    .q_pred  (exe_pred_taken)
  );

`ifdef PCRU_PERF_CNT_EN
  logic [CNT_W-1:0] branches_reg;
  logic [CNT_W-1:0] mispredicts_reg;
  logic             branch_resolved;

  assign branch_resolved = exe_valid & ((|exe_correction) | exe_pred_taken);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
    end else begin
      if (branch_resolved && (branches_reg != '1))
        branches_reg <= branches_reg + 1'b1;
      if (redirect && (mispredicts_reg != '1))
        mispredicts_reg <= mispredicts_reg + 1'b1;
    end
  end

  assign perf_branches    = branches_reg;
  assign perf_mispredicts = mispredicts_reg;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: reset sequencing, predictions, redirects, stall, wrap, perf.
module tb_pc_redirect_unit;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

`ifdef PCRU_PERF_CNT_EN
  localparam int EXP_PERF = 3;
`else
  localparam int EXP_PERF = 0;
`endif

  logic             CLK;
  logic             rst;
  logic             stall;
  logic             if_prediction;
  logic [PC_W-1:0]  if_PBT;
  logic [1:0]       exe_correction;
  logic [PC_W-1:0]  exe_PBT;
  logic [PC_W-1:0]  exe_CNI;
  logic [PC_W-1:0]  if_pc;
  logic [PC_W-1:0]  next_pc;
  logic             id_valid;
  logic             exe_valid;
  logic             id_pred_taken;
  logic             exe_pred_taken;
  logic             flush;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(
    .PC_W    (PC_W),
    .PC_INC  (1),
    .BOOT_PC ('h010),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK              (CLK),
    .rst              (rst),
    .stall            (stall),
    .if_prediction    (if_prediction),
    .if_PBT           (if_PBT),
    .exe_correction   (exe_correction),
    .exe_PBT          (exe_PBT),
    .exe_CNI          (exe_CNI),
    .if_pc            (if_pc),
    .next_pc          (next_pc),
    .id_valid         (id_valid),
    .exe_valid        (exe_valid),
    .id_pred_taken    (id_pred_taken),
    .exe_pred_taken   (exe_pred_taken),
    .flush            (flush),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then settled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [PC_W-1:0] exp_pc;
    rst = 1'b1; stall = 1'b0; if_prediction = 1'b0; if_PBT = '0;
    exe_correction = 2'b00; exe_PBT = '0; exe_CNI = '0;
    tick(); tick();
    checks++;
    if (if_pc !== 10'h010 || id_valid !== 1'b0 || exe_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: if_pc=%h id=%b exe=%b flush=%b, required 010 0 0 0", if_pc, id_valid, exe_valid, flush);
    end
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      exp_pc = 10'h010 + PC_W'(c);
      checks++;
      if (if_pc !== exp_pc || id_valid !== (c >= 1) || exe_valid !== (c >= 2)) begin
        errors++;
        $display("FAIL reset_seq[%0d]: if_pc=%h id=%b exe=%b, required %h %b %b",
                 c, if_pc, id_valid, exe_valid, exp_pc, c >= 1, c >= 2);
      end
      $display("reset cycle %0d: if_pc=%h id_valid=%b exe_valid=%b", c, if_pc, id_valid, exe_valid);
      if (c < 3) tick();
    end
  endtask

  task automatic test_prediction();
    if_prediction = 1'b1; if_PBT = 10'h005;
    tick();
    checks++;
    if (if_pc !== 10'h005) begin
      errors++;
      $display("FAIL pred_setup: if_pc=%h, required 005", if_pc);
    end
    if_PBT = 10'h2A0;
    #1;
    checks++;
    if (next_pc !== 10'h2A0) begin
      errors++;
      $display("FAIL pred_next_pc: next_pc=%h, required 2a0", next_pc);
    end
    tick();
    checks++;
    if (if_pc !== 10'h2A0 || flush !== 1'b0 || id_pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL pred_taken: if_pc=%h flush=%b id_pred=%b, required 2a0 0 1", if_pc, flush, id_pred_taken);
    end
    $display("prediction: if_pc=%h id_pred_taken=%b", if_pc, id_pred_taken);
  endtask

  task automatic test_redirect_pbt();
    exe_correction = 2'b11; exe_PBT = 10'h155; if_prediction = 1'b1; if_PBT = 10'h222;
    #1;
    checks++;
    if (flush !== 1'b1 || next_pc !== 10'h155) begin
      errors++;
      $display("FAIL redir_pbt_comb: flush=%b next_pc=%h, required 1 155", flush, next_pc);
    end
    tick();
    checks++;
    if (if_pc !== 10'h155 || id_valid !== 1'b0 || exe_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL redir_pbt_after: if_pc=%h id=%b exe=%b flush=%b, required 155 0 0 0",
               if_pc, id_valid, exe_valid, flush);
    end
    $display("redirect PBT: if_pc=%h", if_pc);
    exe_correction = 2'b00; if_prediction = 1'b0;
  endtask

  task automatic test_redirect_cni_stall();
    tick(); tick();
    checks++;
    if (if_pc !== 10'h157 || exe_valid !== 1'b1) begin
      errors++;
      $display("FAIL cni_refill: if_pc=%h exe=%b, required 157 1", if_pc, exe_valid);
    end
    stall = 1'b1; exe_correction = 2'b10; exe_CNI = 10'h031; exe_PBT = 10'h0EE;
    #1;
    checks++;
    if (flush !== 1'b1 || next_pc !== 10'h031) begin
      errors++;
      $display("FAIL cni_comb: flush=%b next_pc=%h, required 1 031", flush, next_pc);
    end
    tick();
    checks++;
    if (if_pc !== 10'h031 || id_valid !== 1'b0 || exe_valid !== 1'b0) begin
      errors++;
      $display("FAIL cni_after: if_pc=%h id=%b exe=%b, required 031 0 0", if_pc, id_valid, exe_valid);
    end
    $display("redirect CNI under stall: if_pc=%h", if_pc);
    stall = 1'b0; exe_correction = 2'b00;
  endtask

  task automatic test_stale_and_stall();
    exe_correction = 2'b11; exe_PBT = 10'h100;
    #1;
    checks++;
    if (flush !== 1'b0 || next_pc !== 10'h032) begin
      errors++;
      $display("FAIL stale_corr: flush=%b next_pc=%h, required 0 032", flush, next_pc);
    end
    tick();
    exe_correction = 2'b00;
    checks++;
    if (if_pc !== 10'h032 || id_valid !== 1'b1 || exe_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_after: if_pc=%h id=%b exe=%b, required 032 1 0", if_pc, id_valid, exe_valid);
    end
    tick();
    stall = 1'b1; if_prediction = 1'b1; if_PBT = 10'h0AA;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (if_pc !== 10'h033 || id_valid !== 1'b1 || exe_valid !== 1'b1 || id_pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: if_pc=%h id=%b exe=%b id_pred=%b, required 033 1 1 0",
                 c, if_pc, id_valid, exe_valid, id_pred_taken);
      end
      $display("stall cycle %0d: if_pc=%h", c, if_pc);
    end
    stall = 1'b0; if_prediction = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    if_prediction = 1'b1; if_PBT = 10'h3FF;
    tick();
    if_prediction = 1'b0;
    #1;
    checks++;
    if (if_pc !== 10'h3FF || next_pc !== 10'h000) begin
      errors++;
      $display("FAIL wrap_next: if_pc=%h next_pc=%h, required 3ff 000", if_pc, next_pc);
    end
    tick();
    checks++;
    if (if_pc !== 10'h000) begin
      errors++;
      $display("FAIL wrap_pc: if_pc=%h, required 000", if_pc);
    end
    $display("wrap: if_pc=%h", if_pc);
    tick();
    exe_correction = 2'b11; exe_PBT = 10'h1C3;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (if_pc !== 10'h010 || id_valid !== 1'b0 || exe_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: if_pc=%h id=%b exe=%b flush=%b, required 010 0 0 0",
               if_pc, id_valid, exe_valid, flush);
    end
    $display("async reset: if_pc=%h", if_pc);
    tick();
    exe_correction = 2'b00;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_perf();
    for (int r = 0; r < 3; r++) begin
      tick(); tick();
      exe_correction = 2'b10; exe_CNI = 10'h050;
      tick();
      exe_correction = 2'b00;
      checks++;
      if (if_pc !== 10'h050) begin
        errors++;
        $display("FAIL perf_redirect[%0d]: if_pc=%h, required 050", r, if_pc);
      end
    end
    checks++;
    if (perf_mispredicts !== CNT_W'(EXP_PERF) || perf_branches !== CNT_W'(EXP_PERF)) begin
      errors++;
      $display("FAIL perf_counts: branches=%0d mispredicts=%0d, required %0d %0d",
               perf_branches, perf_mispredicts, EXP_PERF, EXP_PERF);
    end
    $display("perf: branches=%0d mispredicts=%0d", perf_branches, perf_mispredicts);
  endtask

  initial begin
    test_reset();
    test_prediction();
    test_redirect_pbt();
    test_redirect_cni_stall();
    test_stale_and_stall();
    test_wrap_and_async_reset();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
